// File: rtl/dac_cfg_deserializer_pkg.sv
// Shared constants and types for the DAC configuration deserializer:
// GPIO bit map of the bit-banged host protocol, config word sizes,
// commit-vector bit order and the per-register frame state.
package dac_cfg_deserializer_pkg;

  localparam int GPIO_W    = 16;
  localparam int CFG_W     = 256;
  localparam int MUX_BITS  = 8;
  localparam int CFG_CNT_W = 9;
  localparam int N_CFG     = 6;

  // GPIO bit indices used by the host (rfsoc_config map)
  localparam int SDATA_BIT                = 0;
  localparam int MUX_SET_CLK_BIT          = 1;
  localparam int CYCLE_COUNT_CLK_BIT      = 2;
  localparam int MASK_CLK_BIT             = 3;
  localparam int LOCKING_WAVEFORM_CLK_BIT = 4;
  localparam int PRE_DELAY_CYCLE_CLK_BIT  = 5;
  localparam int POST_DELAY_CYCLE_CLK_BIT = 6;

  // Bit positions inside cfg_commit, LSB first
  typedef enum logic [2:0] {
    CMT_MUX   = 3'd0,
    CMT_CYCLE = 3'd1,
    CMT_MASK  = 3'd2,
    CMT_LOCK  = 3'd3,
    CMT_PRE   = 3'd4,
    CMT_POST  = 3'd5
  } commit_bit_e;

  // Frame progress of one serial register
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2
  } reg_state_e;

endpackage

// File: rtl/dac_cfg_deserializer_if.sv
// Bundle between the GPIO host side and the deserializer: raw async
// host pins in, committed configuration words and status pulses out.
interface dac_cfg_if #(
  parameter int CFG_W = dac_cfg_deserializer_pkg::CFG_W
) ();
  logic [dac_cfg_deserializer_pkg::GPIO_W-1:0] gpio_ctrl;
  logic                                        select_in;
  logic                                        mux_sel;
  logic [CFG_W-1:0]                            cycle_count;
  logic [CFG_W-1:0]                            mask;
  logic [CFG_W-1:0]                            locking_waveform;
  logic [CFG_W-1:0]                            pre_delay;
  logic [CFG_W-1:0]                            post_delay;
  logic [dac_cfg_deserializer_pkg::N_CFG-1:0]  cfg_commit;
  logic                                        frame_abort;

  // Host side: drives the GPIO pins, observes committed config
  modport master (
    output gpio_ctrl, select_in,
    input  mux_sel, cycle_count, mask, locking_waveform, pre_delay, post_delay,
    input  cfg_commit, frame_abort
  );

  // Deserializer side
  modport slave (
    input  gpio_ctrl, select_in,
    output mux_sel, cycle_count, mask, locking_waveform, pre_delay, post_delay,
    output cfg_commit, frame_abort
  );
endinterface

// File: rtl/dac_cfg_deserializer_reg.sv
// One serially loaded config register: LSB-first shadow shift, strobe
// counter, IDLE/SHIFT/COMMIT state and atomic update of the output word.
module serial_cfg_reg #(
  parameter int W         = 256,
  parameter int CNT_W     = 9,
  parameter int FRAME_LEN = W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         strobe,
  input  logic         sdata,
  input  logic         abort,
  output logic [W-1:0] value,
  output logic         commit,
  output logic         busy
);
  import dac_cfg_deserializer_pkg::*;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_LEN - 1);

  reg_state_e       state;
  logic [CNT_W-1:0] cnt;
  logic [W-1:0]     shift_nxt;

  if (W > 1) begin : g_wide
    logic [W-1:0] shadow_q;

    // Shadow register: each strobe pushes the new bit in from the top
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) shadow_q <= '0;
      else if (strobe) shadow_q <= {sdata, shadow_q[W-1:1]};
    end

    assign shift_nxt = {sdata, shadow_q[W-1:1]};
  end else begin : g_narrow
    // Single-bit register keeps only the last bit of the frame
    assign shift_nxt = sdata;
  end

  // Frame FSM: count strobes, publish the word on the last one, drop partial frames on abort
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      value  <= '0;
      commit <= 1'b0;
    end else begin
      commit <= 1'b0;
      if (abort) begin
        cnt   <= '0;
        state <= ST_IDLE;
      end else if (strobe) begin
        if (cnt == LAST) begin
          cnt    <= '0;
          value  <= shift_nxt;
          commit <= 1'b1;
          state  <= ST_COMMIT;
        end else begin
          cnt   <= cnt + 1'b1;
          state <= ST_SHIFT;
        end
      end else if (state == ST_COMMIT) begin
        state <= ST_IDLE;
      end
    end
  end

  assign busy = (state == ST_SHIFT);

endmodule

// File: rtl/dac_cfg_deserializer.sv
// Top level: synchronises the async GPIO/select pins, detects strobe
// rising edges gated by select, flags frames cut short by select falling,
// and fans the strobes out to one serial register per config word.
module dac_cfg_deserializer #(
  parameter int CFG_W       = dac_cfg_deserializer_pkg::CFG_W,
  parameter int MUX_BITS    = dac_cfg_deserializer_pkg::MUX_BITS,
  parameter int SYNC_STAGES = 2
) (
  input  logic   clk,
  input  logic   rst,
  dac_cfg_if.slave cfg
);
  import dac_cfg_deserializer_pkg::*;

  localparam int SYNC_W = GPIO_W + 1;

  logic [SYNC_W-1:0] sync_q [SYNC_STAGES];
  logic [SYNC_W-1:0] edge_q;
  logic [GPIO_W-1:0] gpio_s;
  logic [GPIO_W-1:0] rise;
  logic              sel_s;
  logic              sel_fall;
  logic              sdata_s;
  logic [N_CFG-1:0]  stb;
  logic [N_CFG-1:0]  commit;
  logic [N_CFG-1:0]  busy;
  logic              frame_abort_q;
  logic              unused_rise;

  // Synchroniser chain for {select_in, gpio_ctrl}
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= {cfg.select_in, cfg.gpio_ctrl};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  // Previous synced value for edge detection
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) edge_q <= '0;
    else      edge_q <= sync_q[SYNC_STAGES-1];
  end

  assign gpio_s   = sync_q[SYNC_STAGES-1][GPIO_W-1:0];
  assign sel_s    = sync_q[SYNC_STAGES-1][GPIO_W];
  assign rise     = gpio_s & ~edge_q[GPIO_W-1:0];
  assign sel_fall = edge_q[GPIO_W] & ~sel_s;
  assign sdata_s  = gpio_s[SDATA_BIT];
  // Only the strobe lines are edge-qualified; the remaining rise bits are don't-care
  assign unused_rise = ^rise;

  assign stb[CMT_MUX]   = rise[MUX_SET_CLK_BIT]          & sel_s;
  assign stb[CMT_CYCLE] = rise[CYCLE_COUNT_CLK_BIT]      & sel_s;
  assign stb[CMT_MASK]  = rise[MASK_CLK_BIT]             & sel_s;
  assign stb[CMT_LOCK]  = rise[LOCKING_WAVEFORM_CLK_BIT] & sel_s;
  assign stb[CMT_PRE]   = rise[PRE_DELAY_CYCLE_CLK_BIT]  & sel_s;
  assign stb[CMT_POST]  = rise[POST_DELAY_CYCLE_CLK_BIT] & sel_s;

  // Abort pulse only when select drops while some register is mid-frame
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) frame_abort_q <= 1'b0;
    else      frame_abort_q <= sel_fall & (|busy);
  end

  assign cfg.frame_abort = frame_abort_q;
  assign cfg.cfg_commit  = commit;

  serial_cfg_reg #(.W(1), .CNT_W(CFG_CNT_W), .FRAME_LEN(MUX_BITS)) u_mux (
    .clk(clk), .rst(rst), .strobe(stb[CMT_MUX]), .sdata(sdata_s), .abort(sel_fall),
    .value(cfg.mux_sel), .commit(commit[CMT_MUX]), .busy(busy[CMT_MUX])
  );

  serial_cfg_reg #(.W(CFG_W), .CNT_W(CFG_CNT_W), .FRAME_LEN(CFG_W)) u_cycle (
    .clk(clk), .rst(rst), .strobe(stb[CMT_CYCLE]), .sdata(sdata_s), .abort(sel_fall),
    .value(cfg.cycle_count), .commit(commit[CMT_CYCLE]), .busy(busy[CMT_CYCLE])
  );

  serial_cfg_reg #(.W(CFG_W), .CNT_W(CFG_CNT_W), .FRAME_LEN(CFG_W)) u_mask (
    .clk(clk), .rst(rst), .strobe(stb[CMT_MASK]), .sdata(sdata_s), .abort(sel_fall),
    .value(cfg.mask), .commit(commit[CMT_MASK]), .busy(busy[CMT_MASK])
  );

  serial_cfg_reg #(.W(CFG_W), .CNT_W(CFG_CNT_W), .FRAME_LEN(CFG_W)) u_lock (
    .clk(clk), .rst(rst), .strobe(stb[CMT_LOCK]), .sdata(sdata_s), .abort(sel_fall),
    .value(cfg.locking_waveform), .commit(commit[CMT_LOCK]), .busy(busy[CMT_LOCK])
  );

  serial_cfg_reg #(.W(CFG_W), .CNT_W(CFG_CNT_W), .FRAME_LEN(CFG_W)) u_pre (
    .clk(clk), .rst(rst), .strobe(stb[CMT_PRE]), .sdata(sdata_s), .abort(sel_fall),
    .value(cfg.pre_delay), .commit(commit[CMT_PRE]), .busy(busy[CMT_PRE])
  );

  serial_cfg_reg #(.W(CFG_W), .CNT_W(CFG_CNT_W), .FRAME_LEN(CFG_W)) u_post (
    .clk(clk), .rst(rst), .strobe(stb[CMT_POST]), .sdata(sdata_s), .abort(sel_fall),
    .value(cfg.post_delay), .commit(commit[CMT_POST]), .busy(busy[CMT_POST])
  );

endmodule
